// File: rtl/psum_accumulator_tn_pkg.sv
// Shared definitions for the partial-sum accumulator: default geometry and FSM states.
package psum_accumulator_tn_pkg;
  localparam int TN_DEF = 4;
  localparam int FW_DEF = 16;
  localparam int AW_DEF = 24;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/psum_accumulator_tn_if.sv
// Beat input and partial-sum output handshakes of the accumulator, bundled as one interface.
interface psum_accumulator_tn_if
  import psum_accumulator_tn_pkg::*;
#(
  parameter int Tn            = TN_DEF,
  parameter int FEATURE_WIDTH = FW_DEF,
  parameter int ACC_WIDTH     = AW_DEF
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic [Tn*FEATURE_WIDTH-1:0] kernel_sum_tn;
  logic                        out_valid;
  logic                        out_ready;
  logic [Tn*ACC_WIDTH-1:0]     out_psum;
  logic [Tn-1:0]               out_sat;

  modport master (
    output in_valid, kernel_sum_tn, out_ready,
    input  in_ready, out_valid, out_psum, out_sat
  );

  modport slave (
    input  in_valid, kernel_sum_tn, out_ready,
    output in_ready, out_valid, out_psum, out_sat
  );
endinterface

// File: rtl/psum_lane_sat_add.sv
// One lane: signed accumulator plus sign-extended kernel sum, clamped to the accumulator range.
module psum_lane_sat_add
  import psum_accumulator_tn_pkg::*;
#(
  parameter int FEATURE_WIDTH = FW_DEF,
  parameter int ACC_WIDTH     = AW_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]     acc,
  input  logic signed [FEATURE_WIDTH-1:0] beat,
  output logic signed [ACC_WIDTH-1:0]     sum,
  output logic                            sat
);
  localparam int AW = ACC_WIDTH;
  localparam int FW = FEATURE_WIDTH;

  // One guard bit is enough because |beat| never exceeds the accumulator range.
  function automatic logic sat_hit(input logic signed [AW:0] wide);
    return wide[AW] != wide[AW-1];
  endfunction

  function automatic logic signed [AW-1:0] sat_clamp(input logic signed [AW:0] wide);
    if (sat_hit(wide)) begin
      return wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
    return wide[AW-1:0];
  endfunction

  logic signed [AW:0] wide;

  assign wide = {acc[AW-1], acc} + {{(AW+1-FW){beat[FW-1]}}, beat};
  assign sum  = sat_clamp(wide);
  assign sat  = sat_hit(wide);
endmodule

// File: rtl/psum_accumulator_tn.sv
// Accumulates Tn kernel sums over num_tiles beats per group and hands each group off
// through a one-entry holding register; num_groups groups per start, then done.
module psum_accumulator_tn
  import psum_accumulator_tn_pkg::*;
#(
  parameter int Tn            = TN_DEF,
  parameter int FEATURE_WIDTH = FW_DEF,
  parameter int ACC_WIDTH     = AW_DEF,
  parameter int CNT_WIDTH     = CW_DEF
) (
  input  logic                 fast_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_tiles,
  input  logic [CNT_WIDTH-1:0] num_groups,
  psum_accumulator_tn_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 drop_err
);
  localparam int AW = ACC_WIDTH;
  localparam int FW = FEATURE_WIDTH;
  localparam int CW = CNT_WIDTH;

  state_t               state;
  logic [CW-1:0]        tile_cnt;
  logic [CW-1:0]        grp_cnt;
  logic [CW-1:0]        tiles_lim;
  logic [CW-1:0]        grps_lim;

  logic signed [AW-1:0] acc_p1 [Tn];
  logic [Tn-1:0]        sat_p1;
  logic signed [AW-1:0] sum_p0 [Tn];
  logic [Tn-1:0]        sat_p0;
  logic [Tn*AW-1:0]     sum_flat_p0;

  logic [Tn*AW-1:0]     psum_p1;
  logic [Tn-1:0]        osat_p1;
  logic                 vld_p1;

  logic                 last_beat;
  logic                 last_group;
  logic                 in_ready;
  logic                 accept;
  logic                 load;

  // Stage p0: combinational saturating add of the incoming beat onto each accumulator
  for (genvar i = 0; i < Tn; i++) begin : g_lane
    psum_lane_sat_add #(
      .FEATURE_WIDTH(FW),
      .ACC_WIDTH    (AW)
    ) u_add (
      .acc (acc_p1[i]),
      .beat(bus.kernel_sum_tn[i*FW +: FW]),
      .sum (sum_p0[i]),
      .sat (sat_p0[i])
    );
    assign sum_flat_p0[i*AW +: AW] = sum_p0[i];
  end

  assign last_beat  = (tile_cnt == tiles_lim - CW'(1));
  assign last_group = (grp_cnt == grps_lim - CW'(1));
  // Only a group-completing beat can collide with an unconsumed held group.
  assign in_ready   = (state == ACCUM) && !(last_beat && vld_p1 && !bus.out_ready);
  assign accept     = bus.in_valid && in_ready;
  assign load       = accept && last_beat;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p1;
  assign bus.out_psum  = psum_p1;
  assign bus.out_sat   = osat_p1;
  assign busy          = (state != IDLE);

  // Stage p1: accumulators, counters, FSM and output holding register
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tile_cnt  <= '0;
      grp_cnt   <= '0;
      tiles_lim <= '0;
      grps_lim  <= '0;
      for (int i = 0; i < Tn; i++) acc_p1[i] <= '0;
      sat_p1    <= '0;
      psum_p1   <= '0;
      osat_p1   <= '0;
      vld_p1    <= 1'b0;
      done      <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.in_valid && !in_ready) drop_err <= 1'b1;

      // A group loaded on the same edge as a consume replaces it without a bubble.
      if (load) begin
        psum_p1 <= sum_flat_p0;
        osat_p1 <= sat_p1 | sat_p0;
        vld_p1  <= 1'b1;
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1 <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACCUM;
            tile_cnt  <= '0;
            grp_cnt   <= '0;
            tiles_lim <= (num_tiles == '0) ? CW'(1) : num_tiles;
            grps_lim  <= (num_groups == '0) ? CW'(1) : num_groups;
            for (int i = 0; i < Tn; i++) acc_p1[i] <= '0;
            sat_p1    <= '0;
            drop_err  <= bus.in_valid;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (last_beat) begin
              for (int i = 0; i < Tn; i++) acc_p1[i] <= '0;
              sat_p1   <= '0;
              tile_cnt <= '0;
              grp_cnt  <= grp_cnt + CW'(1);
              if (last_group) state <= DRAIN;
            end else begin
              for (int i = 0; i < Tn; i++) acc_p1[i] <= sum_p0[i];
              sat_p1   <= sat_p1 | sat_p0;
              tile_cnt <= tile_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (vld_p1 && bus.out_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
